// File: rtl/gp_lpddr5_cmd_checker.sv
// gp_lpddr5_cmd_checker: passive per-channel LPDDR5 CS/CA protocol checker with sticky flags, pulse and saturating count.
// Define GP_LPDDR5_CHK_CAS_FS_EN to enable the CAS_FS data-window check (err_vec bit4).
module gp_lpddr5_cmd_checker #(
    parameter int NUM_CH      = 2,
    parameter int TREFI_MAX   = 64,
    parameter int ACT2REF_MIN = 6,
    parameter int CAS_WIN     = 8,
    parameter int WCK_HOLD    = 6,
    parameter int CNT_W       = 16
) (
    input  logic                  ck_t,
    input  logic                  ddr_reset_n,
    input  logic [NUM_CH-1:0]     cs,
    input  logic [7*NUM_CH-1:0]   ca,
    input  logic [NUM_CH-1:0]     wck_valid,
    input  logic                  err_clr,
    output logic [5*NUM_CH-1:0]   err_vec,
    output logic [NUM_CH-1:0]     err_pulse,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int RW = $clog2(TREFI_MAX + 1);
    localparam int AW = $clog2(ACT2REF_MIN + 1);
    localparam int WW = $clog2(WCK_HOLD + 1);

    typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND, FS_WAIT} cas_state_t;

    logic [5*NUM_CH-1:0] viol;
    logic [NUM_CH-1:0]   hit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [6:0] cmd;
        logic       is_ref, is_cwr, is_crd, is_act, is_wr, is_rd, is_data, fs_viol;
        logic       ref_arm;
        logic [RW-1:0] ref_cnt;
        logic [AW-1:0] act_cnt;
        logic [WW-1:0] wck_cnt;
        cas_state_t state, state_nxt;

        assign cmd     = ca[7*c +: 7];
        assign is_ref  = cs[c] && cmd == 7'b0001110;
        assign is_cwr  = cs[c] && cmd == 7'b0011100;
        assign is_crd  = cs[c] && cmd == 7'b0011010;
        assign is_act  = cs[c] && cmd[6:4] == 3'b111;
        assign is_wr   = cs[c] && (cmd[6:4] == 3'b011 || cmd[6:3] == 4'b0010 || cmd[6:4] == 3'b010);
        assign is_rd   = cs[c] && cmd[6:5] == 2'b10;
        assign is_data = is_wr || is_rd;

`ifdef GP_LPDDR5_CHK_CAS_FS_EN
        localparam int FW = $clog2(CAS_WIN + 1);
        logic          is_cfs, is_coff, fs_done;
        logic [FW-1:0] fs_cnt;

        assign is_cfs  = cs[c] && cmd == 7'b0011001;
        assign is_coff = cs[c] && cmd == 7'b0011111;
        assign fs_done = fs_cnt == FW'(CAS_WIN - 1);
        assign fs_viol = state == FS_WAIT && !is_data && !is_coff && fs_done;

        always_comb begin
            state_nxt = IDLE;
            if (state == IDLE)
                state_nxt = is_cwr ? WR_PEND : is_crd ? RD_PEND : is_cfs ? FS_WAIT : IDLE;
            else if (state == FS_WAIT)
                state_nxt = (is_data || is_coff || fs_done) ? IDLE : FS_WAIT;
        end

        always_ff @(posedge ck_t or negedge ddr_reset_n)
            if (!ddr_reset_n) fs_cnt <= '0;
            else              fs_cnt <= state == FS_WAIT ? fs_cnt + 1'b1 : '0;
`else
        assign fs_viol = 1'b0;

        always_comb begin
            state_nxt = IDLE;
            if (state == IDLE)
                state_nxt = is_cwr ? WR_PEND : is_crd ? RD_PEND : IDLE;
        end
`endif

        assign viol[5*c +: 5] = {
            fs_viol,
            |wck_cnt && !wck_valid[c],
            (state == WR_PEND && !is_wr) || (state == RD_PEND && !is_rd),
            is_ref && |act_cnt,
            ref_arm && !is_ref && ref_cnt == RW'(TREFI_MAX - 1)
        };
        assign hit[c] = |viol[5*c +: 5];

        // act_cnt / wck_cnt hold the number of edges still inside their window
        always_ff @(posedge ck_t or negedge ddr_reset_n) begin
            if (!ddr_reset_n) begin
                state   <= IDLE;
                ref_arm <= 1'b0;
                ref_cnt <= '0;
                act_cnt <= '0;
                wck_cnt <= '0;
            end else begin
                state   <= state_nxt;
                ref_arm <= is_ref || (ref_arm && !viol[5*c]);
                ref_cnt <= is_ref ? '0 : ref_arm ? ref_cnt + 1'b1 : ref_cnt;
                act_cnt <= is_act ? AW'(ACT2REF_MIN) : |act_cnt ? act_cnt - 1'b1 : act_cnt;
                wck_cnt <= is_data ? WW'(WCK_HOLD) : (viol[5*c+3] || !(|wck_cnt)) ? '0 : wck_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            err_vec   <= '0;
            err_pulse <= '0;
            err_cnt   <= '0;
        end else begin
            err_vec   <= err_clr ? viol : err_vec | viol;
            err_pulse <= hit;
            err_cnt   <= |hit ? (err_clr ? CNT_W'(1) : &err_cnt ? err_cnt : err_cnt + 1'b1)
                              : (err_clr ? '0 : err_cnt);
        end
    end
endmodule
